// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: FSM states, trace record field layout and record packing
package mips_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DRAIN = 2'd3} state_t;
  localparam int ALU_LSB = 0;
  localparam int ALU_W = 32;
  localparam int INSTR_LSB = 32;
  localparam int INSTR_W = 32;
  localparam int STALL_BIT = 64;
  localparam int REGW_BIT = 65;
  localparam int MEMW_BIT = 66;
  localparam int ZERO_BIT = 67;
  localparam int BRANCH_BIT = 68;
  localparam int PC_LSB = 69;
  localparam int PC_W = 10;
  localparam int BODY_W = 79;
  function automatic logic [BODY_W-1:0] pack_body(
    input logic [PC_W-1:0] pc,
    input logic branch, zero, mem_write, reg_write, stall,
    input logic [INSTR_W-1:0] instr,
    input logic [ALU_W-1:0] alu
  );
    logic [BODY_W-1:0] r;
    r = '0;
    r[PC_LSB +: PC_W] = pc;
    r[BRANCH_BIT] = branch;
    r[ZERO_BIT] = zero;
    r[MEMW_BIT] = mem_write;
    r[REGW_BIT] = reg_write;
    r[STALL_BIT] = stall;
    r[INSTR_LSB +: INSTR_W] = instr;
    r[ALU_LSB +: ALU_W] = alu;
    return r;
  endfunction
endpackage

// File: rtl/trace_buf.sv
// trace_buf: DEPTH x W record store, one sync write port, one async read port, no reset on data
module trace_buf #(
  parameter int DEPTH = 8,
  parameter int W = 95
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mips_trace_capture.sv
// mips_trace_capture: arm/trigger trace capture of the MIPS debug bus, drained over a valid/ready port
module mips_trace_capture
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [9:0]                PC,
  input  logic [31:0]               Instruction_out,
  input  logic [31:0]               ALU_result_out,
  input  logic                      Branch_out,
  input  logic                      Zero_out,
  input  logic                      MemWrite_out,
  input  logic                      RegWrite_out,
  input  logic                      stall_out,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      trig_en,
  input  logic [9:0]                trig_pc,
  input  logic                      skip_stalls,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W+78:0]          rd_data,
  output logic [1:0]                state_out,
  output logic [$clog2(DEPTH):0]    count_out,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_t state, state_n;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [TS_W-1:0] ts;
  logic trig, qual, we, rd_fire;
  assign trig = !trig_en || PC == trig_pc;
  assign qual = !skip_stalls || !stall_out;
  assign we = state == ARMED ? trig && qual && !stop
            : state == CAPTURE && qual && count < CW'(DEPTH);
  assign rd_valid = state == DRAIN && count != '0;
  assign rd_fire = rd_valid && rd_ready;
  assign state_out = state;
  assign count_out = count;
  assign full = count == CW'(DEPTH);
  always_comb
    state_n = state == IDLE    ? (arm ? ARMED : IDLE)
            : state == ARMED   ? (stop ? DRAIN : trig ? CAPTURE : ARMED)
            : state == CAPTURE ? ((stop || (we && count == CW'(DEPTH - 1))) ? DRAIN : CAPTURE)
            : (count == '0 ? IDLE : DRAIN);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
      state <= state_n;
      if (state == IDLE && arm) begin
        count <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (we) wptr <= wptr + 1'b1;
        if (rd_fire) rptr <= rptr + 1'b1;
        count <= count + CW'(we) - CW'(rd_fire);
      end
    end
  trace_buf #(.DEPTH(DEPTH), .W(TS_W + BODY_W)) u_buf (
    .clock(clock),
    .we(we),
    .waddr(wptr),
    .wdata({ts, pack_body(PC, Branch_out, Zero_out, MemWrite_out, RegWrite_out, stall_out,
                          Instruction_out, ALU_result_out)}),
    .raddr(rptr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_mips_trace_capture.sv
// tb_mips_trace_capture: directed sessions with random bus data checked against a record queue model
module tb_mips_trace_capture;
  localparam int RW = 95;
  logic clock, reset;
  logic [9:0] PC, trig_pc;
  logic [31:0] Instruction_out, ALU_result_out;
  logic Branch_out, Zero_out, MemWrite_out, RegWrite_out, stall_out;
  logic arm, stop, trig_en, skip_stalls, rd_valid, rd_ready, full;
  logic [RW-1:0] rd_data;
  logic [1:0] state_out;
  logic [3:0] count_out;
  logic [15:0] ts_m;
  logic [RW-1:0] q[$];
  int tests = 0;
  int fails = 0;
  mips_trace_capture #(.DEPTH(8), .TS_W(16)) dut (
    .clock(clock), .reset(reset), .PC(PC), .Instruction_out(Instruction_out),
    .ALU_result_out(ALU_result_out), .Branch_out(Branch_out), .Zero_out(Zero_out),
    .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out), .stall_out(stall_out),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc), .skip_stalls(skip_stalls),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .state_out(state_out),
    .count_out(count_out), .full(full)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) ts_m <= reset ? 16'd0 : ts_m + 16'd1;
  task automatic chk(input string tag, input logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask
  function automatic logic [RW-1:0] rec();
    return {ts_m, PC, Branch_out, Zero_out, MemWrite_out, RegWrite_out, stall_out,
            Instruction_out, ALU_result_out};
  endfunction
  task automatic sample(input logic [9:0] pc, input logic st, input logic keep);
    PC = pc;
    Instruction_out = $urandom;
    ALU_result_out = $urandom;
    {Branch_out, Zero_out, MemWrite_out, RegWrite_out} = 4'($urandom);
    stall_out = st;
    if (keep) q.push_back(rec());
  endtask
  task automatic drain(input int pat);
    int k = 0;
    int guard = 0;
    logic stalled = 1'b0;
    logic [RW-1:0] held = '0;
    while (q.size() > 0 && guard < 200) begin
      rd_ready = pat == 0 ? 1'b1 : (k % 3 == 0);
      if (rd_valid) begin
        if (stalled) chk("hold_stable", rd_data === held);
        if (rd_ready) begin
          chk("record", rd_data === q.pop_front());
          stalled = 1'b0;
        end else begin
          held = rd_data;
          stalled = 1'b1;
        end
      end
      k++;
      guard++;
      @(negedge clock);
    end
    rd_ready = 1'b0;
    chk("drain_left", q.size() == 0);
    chk("drain_state", state_out === 2'd3);
    chk("drain_valid_empty", rd_valid === 1'b0);
    @(negedge clock);
    chk("idle_after_drain", state_out === 2'd0);
  endtask
  initial begin
    reset = 1'b1; arm = 0; stop = 0; trig_en = 0; trig_pc = '0; skip_stalls = 0; rd_ready = 0;
    sample(10'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    chk("rst_state", state_out === 2'd0);
    chk("rst_count", count_out === 4'd0);
    chk("rst_valid", rd_valid === 1'b0);
    chk("rst_full", full === 1'b0);
    reset = 1'b0;
    while (ts_m != 16'd9) @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s1_state", state_out === 2'(i == 0 ? 1 : 2));
      chk("s1_no_valid", rd_valid === 1'b0);
      sample(10'(4 * i), 1'($urandom), 1'b1);
      @(negedge clock);
    end
    sample(10'h020, 1'b0, 1'b0);
    chk("s1_drain", state_out === 2'd3);
    chk("s1_count", count_out === 4'd8);
    chk("s1_full", full === 1'b1);
    chk("s1_first_ts", rd_data[94:79] === 16'd10);
    drain(0);
    chk("s1_full_clear", full === 1'b0);
    trig_en = 1'b1; trig_pc = 10'h010;
    sample(10'h000, 1'b0, 1'b0);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s2_armed", state_out === 2'd1);
      sample(10'(4 * i), 1'b0, 1'b0);
      @(negedge clock);
    end
    chk("s2_armed_at_match", state_out === 2'd1);
    sample(10'h010, 1'($urandom), 1'b1);
    @(negedge clock);
    chk("s2_capture", state_out === 2'd2);
    sample(10'h014, 1'($urandom), 1'b1);
    @(negedge clock);
    stop = 1'b1;
    sample(10'h018, 1'($urandom), 1'b1);
    @(negedge clock);
    stop = 1'b0;
    sample(10'h01c, 1'b0, 1'b0);
    chk("s2_drain", state_out === 2'd3);
    chk("s2_count", count_out === 4'd3);
    chk("s2_first_pc", rd_data[78:69] === 10'h010);
    drain(1);
    trig_en = 1'b0; skip_stalls = 1'b1;
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic st;
      st = (i == 3 || i == 6);
      chk("s3_state", state_out === 2'(i == 0 ? 1 : 2));
      sample(10'(256 + 4 * i), st, !st);
      @(negedge clock);
    end
    chk("s3_drain", state_out === 2'd3);
    chk("s3_count", count_out === 4'd8);
    drain(0);
    skip_stalls = 1'b0;
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s4_state", state_out === 2'(i == 0 ? 1 : 2));
      arm = (i == 2);
      stop = (i == 4);
      sample(10'(512 + 4 * i), 1'($urandom), 1'b1);
      @(negedge clock);
      arm = 1'b0;
      stop = 1'b0;
    end
    chk("s4_drain", state_out === 2'd3);
    chk("s4_count", count_out === 4'd5);
    chk("s4_valid", rd_valid === 1'b1);
    chk("s4_head", rd_data === q[0]);
    rd_ready = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("s4_rst_state", state_out === 2'd0);
    chk("s4_rst_count", count_out === 4'd0);
    chk("s4_rst_valid", rd_valid === 1'b0);
    reset = 1'b0;
    rd_ready = 1'b0;
    q.delete();
    trig_en = 1'b1; trig_pc = 10'h3ff;
    sample(10'h000, 1'b0, 1'b0);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    chk("s5_armed", state_out === 2'd1);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("s5_drain", state_out === 2'd3);
    chk("s5_valid", rd_valid === 1'b0);
    chk("s5_count", count_out === 4'd0);
    @(negedge clock);
    chk("s5_idle", state_out === 2'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_trace_capture.md
Name: mips_trace_capture

Overview:
- Hardware trace unit that sits on the MIPS processor's debug observation bus (PC, Instruction_out, ALU_result_out, status flags) and is the consuming end of that interface.
- Once armed and triggered, it records one snapshot per qualifying cycle into an internal buffer.
- After capture it drains the records through a valid/ready readout port to a host, bench or UART bridge.

Parameters:
- DEPTH, 8, number of trace records held; power of two, at least 2.
- TS_W, 16, width of the free-running cycle timestamp stored in each record.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PC  in  10  processor PC.
- Instruction_out  in  32  processor instruction.
- ALU_result_out  in  32  processor ALU result.
- Branch_out  in  1  processor branch flag.
- Zero_out  in  1  processor zero flag.
- MemWrite_out  in  1  processor memory-write flag.
- RegWrite_out  in  1  processor register-write flag.
- stall_out  in  1  processor stall flag.
- arm  in  1  single-cycle pulse; starts a capture session.
- stop  in  1  single-cycle pulse; ends capture early.
- trig_en  in  1  1 = wait for a PC match; 0 = trigger immediately on arm.
- trig_pc  in  10  PC value to match.
- skip_stalls  in  1  1 = do not record cycles where stall_out = 1.
- rd_valid  out  1  record available on rd_data.
- rd_ready  in  1  consumer accepts the record.
- rd_data  out  TS_W+79  record, MSB to LSB: {timestamp, PC, Branch, Zero, MemWrite, RegWrite, stall, Instruction, ALU_result}.
- state_out  out  2  current FSM state encoding.
- count_out  out  clog2(DEPTH)+1  records currently held.
- full  out  1  count equals DEPTH.

Behaviour:
- Reset values: state IDLE, count 0, write and read pointers 0, timestamp 0, rd_valid 0, full 0.
- Timestamp: increments every cycle while reset = 0 and wraps modulo 2^TS_W. A record holds the timestamp of its sample cycle.
- FSM encoding: IDLE = 0, ARMED = 1, CAPTURE = 2, DRAIN = 3.
- IDLE:
  - arm moves to ARMED and clears count and both pointers.
  - stop and rd_ready are ignored.
- ARMED:
  - Trigger condition: trig_en = 0, or PC == trig_pc.
  - Trigger is evaluated every cycle, including the first ARMED cycle.
  - The trigger cycle itself is a qualifying sample. If qualified, it is written as record 0 on the same edge that enters CAPTURE.
  - stop in ARMED goes to DRAIN with count 0, then to IDLE on the next cycle.
- CAPTURE:
  - Each cycle with (skip_stalls = 0 or stall_out = 0) and count < DEPTH writes the current inputs at wptr.
  - That write increments wptr and count.
  - Exit to DRAIN on the edge where count reaches DEPTH, or on stop.
  - A stop coinciding with a qualifying sample still records that sample.
- DRAIN:
  - rd_valid = 1 exactly when count > 0.
  - rd_data = buffer[rptr], combinationally readable with no added latency.
  - A transfer occurs when rd_valid and rd_ready are both 1. It advances rptr and decrements count.
  - rd_data must hold stable while rd_valid = 1 and rd_ready = 0.
  - The state returns to IDLE on the cycle after count becomes 0.
- Other rules:
  - arm outside IDLE is ignored.
  - rd_valid is never 1 outside DRAIN.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - No overflow is possible: capture halts at full.
  - reset mid-session discards all records and returns to IDLE on the next edge, whatever rd_ready is.
  - trig_pc, trig_en and skip_stalls are sampled live; they must not change while not in IDLE.

Decomposition:
- Package mips_trace_pkg holds:
  - the state enum;
  - the record field offsets and widths;
  - a record-pack function.
- Sub-module trace_buf: DEPTH x record-width storage with one write port and one asynchronous read port, no reset on the data array.
- The FSM, counters and timestamp live in the top level.

Test Plan:
- Immediate trigger, full capture:
  - Stimulus: trig_en = 0, skip_stalls = 0, arm at timestamp 10, PC stepping 0, 4, 8, …, rd_ready = 1.
  - Required: 8 records with PCs 0x000 to 0x01C and timestamps 10 to 17; full = 1 for one cycle; back in IDLE after the 8th transfer.
- PC trigger:
  - Stimulus: trig_en = 1, trig_pc = 0x010, arm while PC = 0x000.
  - Required: state stays ARMED until PC = 0x010; record 0 has PC = 0x010.
- Stall filter:
  - Stimulus: skip_stalls = 1, stall_out high for 2 of 10 capture cycles.
  - Required: the stalled cycles are absent; timestamps show the gaps; the stall bit is 0 in every record.
- Early stop with backpressure:
  - Stimulus: stop after 3 records; rd_ready toggling 1, 0, 0, 1, …
  - Required: count_out = 3; rd_data stable while stalled; exactly 3 transfers in order.
- Ignored controls and reset:
  - Stimulus: arm pulsed during CAPTURE, then reset asserted in DRAIN with count = 5.
  - Required: the extra arm has no effect; after reset, state_out = 0, count_out = 0, rd_valid = 0 on the next cycle.
- Stop while ARMED:
  - Stimulus: trig_en = 1 with no PC match, then stop.
  - Required: DRAIN for one cycle with rd_valid = 0, then IDLE.
